// File: rtl/jtag_unlock_ctrl.sv
// Serial key-check controller feeding the JTAG lock register.
// Shifts a key in MSB first, unlocks only on an exact match, and enforces a timed lockout after repeated failures.
module jtag_unlock_ctrl #(
    parameter int               KEY_W          = 32,
    parameter logic [KEY_W-1:0] KEY            = 32'hA5C3_5A3C,
    parameter int               MAX_TRIES      = 3,
    parameter int               LOCKOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               d,
    input  logic                               en,
    input  logic                               relock,
    output logic                               lock_jtag_status,
    output logic                               lockout,
    output logic                               busy,
    output logic [$clog2(MAX_TRIES+1)-1:0]     fail_count
);

    localparam int BW = $clog2(KEY_W);
    localparam int FW = $clog2(MAX_TRIES + 1);
    localparam int TW = $clog2(LOCKOUT_CYCLES);

    typedef enum logic [1:0] {
        S_LOCKED,
        S_CHECK,
        S_UNLOCKED,
        S_LOCKOUT
    } state_t;

    state_t           state, state_n;
    logic [KEY_W-1:0] shreg, shreg_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [TW-1:0]    timer, timer_n;
    logic [FW-1:0]    fail_n;

    // NOTE: every next-value signal gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_n   = state;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        timer_n   = timer;
        fail_n    = fail_count;

        case (state)
            S_LOCKED: begin
                if (relock) begin
                    shreg_n   = '0;
                    bit_cnt_n = '0;
                end else if (en) begin
                    shreg_n = {shreg[KEY_W-2:0], d};
                    if (bit_cnt == BW'(KEY_W - 1)) begin
                        bit_cnt_n = '0;
                        state_n   = S_CHECK;
                    end else begin
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
            end

            S_CHECK: begin
                shreg_n = '0;
                if (shreg == KEY) begin
                    fail_n  = '0;
                    state_n = S_UNLOCKED;
                end else if (int'(fail_count) + 1 < MAX_TRIES) begin
                    fail_n  = fail_count + 1'b1;
                    state_n = S_LOCKED;
                end else begin
                    fail_n  = FW'(MAX_TRIES);
                    timer_n = TW'(LOCKOUT_CYCLES - 1);
                    state_n = S_LOCKOUT;
                end
            end

            S_UNLOCKED: begin
                shreg_n = '0;
                if (relock) begin
                    state_n = S_LOCKED;
                end
            end

            S_LOCKOUT: begin
                if (timer == '0) begin
                    fail_n  = '0;
                    state_n = S_LOCKED;
                end else begin
                    timer_n = timer - 1'b1;
                end
            end

            default: state_n = S_LOCKED;
        endcase
    end

    // Status outputs are registered from the next state so they change together with it and never glitch.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= S_LOCKED;
            shreg            <= '0;
            bit_cnt          <= '0;
            timer            <= '0;
            fail_count       <= '0;
            lock_jtag_status <= 1'b1;
            lockout          <= 1'b0;
            busy             <= 1'b0;
        end else begin
            state            <= state_n;
            shreg            <= shreg_n;
            bit_cnt          <= bit_cnt_n;
            timer            <= timer_n;
            fail_count       <= fail_n;
            lock_jtag_status <= (state_n != S_UNLOCKED);
            lockout          <= (state_n == S_LOCKOUT);
            busy             <= (state_n == S_CHECK);
        end
    end

endmodule

// File: tb/tb_jtag_unlock_ctrl.sv
// Self-checking bench for jtag_unlock_ctrl: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a queue-based behavioural model.
module tb_jtag_unlock_ctrl;

    localparam int         KEY_W          = 8;
    localparam logic [7:0] KEY            = 8'hA5;
    localparam int         MAX_TRIES      = 3;
    localparam int         LOCKOUT_CYCLES = 16;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       d = 1'b0;
    logic       en = 1'b0;
    logic       relock = 1'b0;
    logic       lock_jtag_status;
    logic       lockout;
    logic       busy;
    logic [1:0] fail_count;

    int n_checks = 0;
    int n_fails  = 0;

    jtag_unlock_ctrl #(
        .KEY_W(KEY_W),
        .KEY(KEY),
        .MAX_TRIES(MAX_TRIES),
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .d(d),
        .en(en),
        .relock(relock),
        .lock_jtag_status(lock_jtag_status),
        .lockout(lockout),
        .busy(busy),
        .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: collected bits in a queue, flags and counters updated per edge.
    logic m_valid = 1'b0;
    logic m_bits[$];
    logic m_check_pending = 1'b0;
    logic m_unlocked = 1'b0;
    logic [7:0] m_word = 8'h00;
    int   m_fails = 0;
    int   m_lockout_left = 0;

    always @(posedge clk) begin
        if (!resetn) begin
            m_valid = 1'b1;
            m_bits.delete();
            m_check_pending = 1'b0;
            m_unlocked = 1'b0;
            m_fails = 0;
            m_lockout_left = 0;
        end else if (m_check_pending) begin
            m_check_pending = 1'b0;
            if (m_word == KEY) begin
                m_unlocked = 1'b1;
                m_fails = 0;
            end else begin
                m_fails++;
                if (m_fails == MAX_TRIES) m_lockout_left = LOCKOUT_CYCLES;
            end
        end else if (m_lockout_left > 0) begin
            m_lockout_left--;
            if (m_lockout_left == 0) m_fails = 0;
        end else if (m_unlocked) begin
            if (relock) m_unlocked = 1'b0;
        end else if (relock) begin
            m_bits.delete();
        end else if (en) begin
            m_bits.push_back(d);
            if (m_bits.size() == KEY_W) begin
                m_word = 8'h00;
                foreach (m_bits[i]) m_word = {m_word[6:0], m_bits[i]};
                m_bits.delete();
                m_check_pending = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_lock",    int'(lock_jtag_status), int'(!m_unlocked));
            check("model_lockout", int'(lockout),          int'(m_lockout_left > 0));
            check("model_busy",    int'(busy),             int'(m_check_pending));
            check("model_fails",   int'(fail_count),       m_fails);
        end
    end

    // Inputs change at the negedge; returns at the negedge after the next rising edge.
    task automatic step(input logic e, input logic dv, input logic r, input logic rn);
        en = e;
        d = dv;
        relock = r;
        resetn = rn;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic shift_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) step(1'b1, b[i], 1'b0, 1'b1);
    endtask

    task automatic expect_unlock(input string tag);
        check({tag, "_busy"}, int'(busy), 1);
        check({tag, "_lock_during_check"}, int'(lock_jtag_status), 1);
        idle(1);
        check({tag, "_lock"}, int'(lock_jtag_status), 0);
        check({tag, "_fails"}, int'(fail_count), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic do_relock();
        step(1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic force_lockout();
        for (int a = 0; a < MAX_TRIES; a++) begin
            shift_bits(8'h00, 8);
            idle(1);
        end
    endtask

    initial begin
        int cnt;
        logic [7:0] kb;
        @(negedge clk);
        idle(0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_lock", int'(lock_jtag_status), 1);
        check("rst_lockout", int'(lockout), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_fails", int'(fail_count), 0);
        idle(2);

        // Plain unlock and relock
        shift_bits(KEY, 8);
        expect_unlock("unlock1");
        do_relock();
        check("relock1_lock", int'(lock_jtag_status), 1);

        // One miss, then a hit
        shift_bits(8'hA4, 8);
        idle(1);
        check("miss1_fails", int'(fail_count), 1);
        check("miss1_lock", int'(lock_jtag_status), 1);
        shift_bits(KEY, 8);
        expect_unlock("unlock2");
        do_relock();

        // Three misses force lockout of exactly LOCKOUT_CYCLES cycles
        force_lockout();
        check("lo_fails", int'(fail_count), 3);
        check("lo_flag", int'(lockout), 1);
        cnt = 1;
        kb = KEY;
        for (int k = 0; k < 40 && lockout; k++) begin
            if (k < 8) step(1'b1, kb[7-k], 1'b0, 1'b1);
            else       idle(1);
            if (lockout) cnt++;
            check("lo_lock_held", int'(lock_jtag_status), 1);
        end
        check("lo_cycles", cnt, LOCKOUT_CYCLES);
        check("lo_end_fails", int'(fail_count), 0);
        check("lo_end_busy", int'(busy), 0);
        shift_bits(KEY, 8);
        expect_unlock("unlock3");

        // Unlocked: en ignored, relock relocks
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("unl_en_ignored", int'(lock_jtag_status), 0);
        do_relock();
        check("relock2_lock", int'(lock_jtag_status), 1);

        // Partial entry aborted by relock with a simultaneous en
        shift_bits(KEY, 4);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        shift_bits(KEY, 8);
        expect_unlock("unlock4");
        do_relock();

        // Reset mid-entry
        shift_bits(KEY, 5);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("rst_mid_lock", int'(lock_jtag_status), 1);
        check("rst_mid_busy", int'(busy), 0);
        shift_bits(KEY, 8);
        expect_unlock("unlock5");
        do_relock();

        // Reset mid-lockout
        force_lockout();
        idle(5);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("rst_lo_lockout", int'(lockout), 0);
        check("rst_lo_fails", int'(fail_count), 0);
        check("rst_lo_lock", int'(lock_jtag_status), 1);
        shift_bits(KEY, 8);
        expect_unlock("unlock6");
        do_relock();

        // Randomized traffic, checked every cycle by the model
        for (int it = 0; it < 3000; it++) begin
            if ($urandom_range(9) == 0) begin
                logic [7:0] w;
                w = ($urandom_range(1) == 0) ? KEY : 8'($urandom);
                for (int b = 7; b >= 0; b--) begin
                    if ($urandom_range(3) == 0) idle(1);
                    step(1'b1, w[b], 1'b0, 1'b1);
                end
            end else begin
                step(1'($urandom), 1'($urandom),
                     ($urandom_range(15) == 0), ($urandom_range(199) != 0));
            end
        end
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
